// File: rtl/cc_stack_pkg.sv
// Shared definitions for the condition-code stack: flag bit positions and the
// Y86 jXX/cmovXX function codes used by the optional condition decoder.
package cc_stack_pkg;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;
  localparam int CC_CF = 3;

  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } ifun_e;

endpackage

// File: rtl/cc_cond.sv
// Combinational Y86 condition decode from ZF/SF/OF and a jXX/cmovXX function code.
// Used by cc_stack only when CC_COND_EVAL_EN is defined.
module cc_cond
  import cc_stack_pkg::*;
(
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic [3:0] ifun,
  output logic       cond
);

  logic lt;
  assign lt = sf ^ of;

  always_comb begin
    cond = 1'b0;
    case (ifun)
      C_YES:   cond = 1'b1;
      C_LE:    cond = lt | zf;
      C_L:     cond = lt;
      C_E:     cond = zf;
      C_NE:    cond = ~zf;
      C_GE:    cond = ~lt;
      C_G:     cond = ~lt & ~zf;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_stack.sv
// Condition-code register with a LIFO checkpoint stack for interrupt/call save-restore.
// Define CC_COND_EVAL_EN to add the ifun input and the cond output (cc_cond decoder).
module cc_stack
  import cc_stack_pkg::*;
#(
  parameter  int CC_W  = 4,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CC_W-1:0]  new_cc,
  input  logic             set_cc,
  input  logic             push,
  input  logic             pop,
`ifdef CC_COND_EVAL_EN
  input  logic [3:0]       ifun,
  output logic             cond,
`endif
  output logic [CC_W-1:0]  cc,
  output logic [PTR_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CC_W-1:0]  cc_q, cc_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             err_q, err_d;
  logic [CC_W-1:0]  stack_q [DEPTH-1:0];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] lvl_idx;

  assign full    = (level_q == PTR_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign top_idx = IDX_W'(level_q - PTR_W'(1));
  assign lvl_idx = IDX_W'(level_q);

  // pop outranks set_cc; the stack entry written on push always holds the pre-edge cc
  always_comb begin
    cc_d    = cc_q;
    level_d = level_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = lvl_idx;
    if (pop) begin
      if (!empty) begin
        cc_d = stack_q[top_idx];
        if (push) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          level_d = level_q - PTR_W'(1);
        end
      end else begin
        err_d = 1'b1;
        if (set_cc) cc_d = new_cc;
      end
    end else begin
      if (set_cc) cc_d = new_cc;
      if (push) begin
        if (!full) begin
          wr_en   = 1'b1;
          level_d = level_q + PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cc_q    <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cc_q    <= cc_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Contents are meaningless after reset because level returns to 0.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) stack_q[wr_idx] <= cc_q;
  end

  assign cc    = cc_q;
  assign level = level_q;
  assign err   = err_q;

`ifdef CC_COND_EVAL_EN
  cc_cond u_cc_cond (
    .zf   (cc_q[CC_ZF]),
    .sf   (cc_q[CC_SF]),
    .of   (cc_q[CC_OF]),
    .ifun (ifun),
    .cond (cond)
  );
`endif

endmodule

// File: tb/tb_cc_stack.sv
// Self-checking bench for cc_stack: directed scenarios plus random push/pop/set_cc
// traffic compared against a queue-based reference model.
module tb_cc_stack;
  import cc_stack_pkg::*;

  localparam int CC_W  = 4;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [CC_W-1:0]  new_cc = '0;
  logic             set_cc = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [CC_W-1:0]  cc;
  logic [PTR_W-1:0] level;
  logic             full, empty, err;
`ifdef CC_COND_EVAL_EN
  logic [3:0]       ifun = '0;
  logic             cond;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [CC_W-1:0] m_cc;
  logic [CC_W-1:0] m_stack [$];
  logic            m_err;

  cc_stack #(.CC_W(CC_W), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .new_cc (new_cc),
    .set_cc (set_cc),
    .push   (push),
    .pop    (pop),
`ifdef CC_COND_EVAL_EN
    .ifun   (ifun),
    .cond   (cond),
`endif
    .cc     (cc),
    .level  (level),
    .full   (full),
    .empty  (empty),
    .err    (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] f, input logic [CC_W-1:0] c);
    logic zf, sf, of;
    zf = c[0]; sf = c[1]; of = c[2];
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return (sf != of) || zf;
      4'd2:    return sf != of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return sf == of;
      4'd6:    return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    logic [CC_W-1:0] t;
    if (reset) begin
      m_cc = '0; m_err = 1'b0; m_stack.delete();
    end else if (pop && push) begin
      if (m_stack.size() > 0) begin
        t = m_stack.pop_back(); m_stack.push_back(m_cc); m_cc = t;
      end else begin
        m_err = 1'b1;
        if (set_cc) m_cc = new_cc;
      end
    end else if (pop) begin
      if (m_stack.size() > 0) m_cc = m_stack.pop_back();
      else begin
        m_err = 1'b1;
        if (set_cc) m_cc = new_cc;
      end
    end else begin
      if (push) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(m_cc);
        else m_err = 1'b1;
      end
      if (set_cc) m_cc = new_cc;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cc"},    32'(cc),    32'(m_cc));
    check({tag, ".level"}, 32'(level), 32'(m_stack.size()));
    check({tag, ".full"},  32'(full),  32'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(m_stack.size() == 0));
    check({tag, ".err"},   32'(err),   32'(m_err));
`ifdef CC_COND_EVAL_EN
    check({tag, ".cond"},  32'(cond),  32'(ref_cond(ifun, m_cc)));
`endif
  endtask

  // Drive at the falling edge, let one rising edge act, compare at the next falling edge.
  task automatic step(input string tag, input logic s, input logic [CC_W-1:0] n,
                      input logic pu, input logic po);
    set_cc = s; new_cc = n; push = pu; pop = po;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step("rst", 1'b1, 4'hF, 1'b0, 1'b0);
    step("rst", 1'b1, 4'hF, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    m_cc = '0; m_err = 1'b0;
    @(negedge clock);

    // reset with set_cc asserted
    do_reset();
    check("rst_cc", 32'(cc), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);

    // push saves old flags while set_cc loads new ones
    step("t2a", 1'b1, 4'h5, 1'b0, 1'b0);
    step("t2b", 1'b1, 4'hA, 1'b1, 1'b0);
    check("t2_cc", 32'(cc), 32'hA);
    check("t2_level", 32'(level), 32'h1);
    step("t2c", 1'b0, 4'h0, 1'b0, 1'b1);
    check("t2_restore", 32'(cc), 32'h5);

    // fill, overflow, then unwind in LIFO order
    do_reset();
    step("t3set", 1'b1, 4'h1, 1'b0, 1'b0);
    for (int v = 2; v <= 9; v++) step("t3push", 1'b1, CC_W'(v), 1'b1, 1'b0);
    check("t3_full", 32'(full), 32'h1);
    step("t3ovf", 1'b0, 4'h0, 1'b1, 1'b0);
    check("t3_ovf_level", 32'(level), 32'(DEPTH));
    check("t3_ovf_err", 32'(err), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step("t3pop", 1'b0, 4'h0, 1'b0, 1'b1);
      check("t3_lifo", 32'(cc), 32'(8 - i));
    end

    // underflow honours set_cc; non-empty pop ignores it
    do_reset();
    step("t4set", 1'b1, 4'h3, 1'b0, 1'b0);
    step("t4unf", 1'b1, 4'h6, 1'b0, 1'b1);
    check("t4_unf_cc", 32'(cc), 32'h6);
    check("t4_unf_err", 32'(err), 32'h1);
    step("t4push", 1'b1, 4'h1, 1'b1, 1'b0);
    step("t4pop", 1'b1, 4'hF, 1'b0, 1'b1);
    check("t4_pop_wins", 32'(cc), 32'h6);

    // swap
    do_reset();
    step("t5set", 1'b1, 4'h9, 1'b0, 1'b0);
    step("t5push", 1'b1, 4'h2, 1'b1, 1'b0);
    step("t5swap", 1'b1, 4'h7, 1'b1, 1'b1);
    check("t5_swap_cc", 32'(cc), 32'h9);
    check("t5_swap_level", 32'(level), 32'h1);
    step("t5pop", 1'b0, 4'h0, 1'b0, 1'b1);
    check("t5_swap_top", 32'(cc), 32'h2);
    step("t5bothempty", 1'b1, 4'hC, 1'b1, 1'b1);
    check("t5_unf_swap_cc", 32'(cc), 32'hC);

`ifdef CC_COND_EVAL_EN
    step("t6set", 1'b1, 4'b0010, 1'b0, 1'b0);
    ifun = 4'd2; #1 check("t6_l",  32'(cond), 32'h1);
    ifun = 4'd5; #1 check("t6_ge", 32'(cond), 32'h0);
    ifun = 4'd4; #1 check("t6_ne", 32'(cond), 32'h1);
    ifun = 4'd9; #1 check("t6_bad", 32'(cond), 32'h0);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
`ifdef CC_COND_EVAL_EN
      ifun = 4'($urandom_range(0, 15));
`endif
      if ($urandom_range(0, 79) == 0) reset = 1'b1;
      step("rnd", 1'($urandom_range(0, 1)), CC_W'($urandom),
           ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 4));
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
